// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment display path.
//   - Segment-pattern constants (active-low, order {a,b,c,d,e,f,g}).
//   - Segment bit positions within the 8-bit bus {a,b,c,d,e,f,g,dp}.
//   - seg_decode(): 7-bit pattern -> {hit, nibble}.
//   - scan_state_e: capture FSM states.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int unsigned SEG_BIT_A  = 7;
    localparam int unsigned SEG_BIT_B  = 6;
    localparam int unsigned SEG_BIT_C  = 5;
    localparam int unsigned SEG_BIT_D  = 4;
    localparam int unsigned SEG_BIT_E  = 3;
    localparam int unsigned SEG_BIT_F  = 2;
    localparam int unsigned SEG_BIT_G  = 1;
    localparam int unsigned SEG_BIT_DP = 0;

    localparam logic [6:0] SEG_PAT_0 = 7'b0000001;
    localparam logic [6:0] SEG_PAT_1 = 7'b1001111;
    localparam logic [6:0] SEG_PAT_2 = 7'b0010010;
    localparam logic [6:0] SEG_PAT_3 = 7'b0000110;
    localparam logic [6:0] SEG_PAT_4 = 7'b1001100;
    localparam logic [6:0] SEG_PAT_5 = 7'b0100100;
    localparam logic [6:0] SEG_PAT_6 = 7'b0100000;
    localparam logic [6:0] SEG_PAT_7 = 7'b0001111;
    localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9 = 7'b0001100;
    localparam logic [6:0] SEG_PAT_A = 7'b0001000;
    localparam logic [6:0] SEG_PAT_B = 7'b1100000;
    localparam logic [6:0] SEG_PAT_C = 7'b1110010;
    localparam logic [6:0] SEG_PAT_D = 7'b1000010;
    localparam logic [6:0] SEG_PAT_E = 7'b0110000;
    localparam logic [6:0] SEG_PAT_F = 7'b0111000;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } scan_state_e;

    // Returns {hit, nibble}; hit=0 (nibble=0) for any unrecognised pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        res = '0;
        case (pat)
            SEG_PAT_0: res = {1'b1, 4'h0};
            SEG_PAT_1: res = {1'b1, 4'h1};
            SEG_PAT_2: res = {1'b1, 4'h2};
            SEG_PAT_3: res = {1'b1, 4'h3};
            SEG_PAT_4: res = {1'b1, 4'h4};
            SEG_PAT_5: res = {1'b1, 4'h5};
            SEG_PAT_6: res = {1'b1, 4'h6};
            SEG_PAT_7: res = {1'b1, 4'h7};
            SEG_PAT_8: res = {1'b1, 4'h8};
            SEG_PAT_9: res = {1'b1, 4'h9};
            SEG_PAT_A: res = {1'b1, 4'hA};
            SEG_PAT_B: res = {1'b1, 4'hB};
            SEG_PAT_C: res = {1'b1, 4'hC};
            SEG_PAT_D: res = {1'b1, 4'hD};
            SEG_PAT_E: res = {1'b1, 4'hE};
            SEG_PAT_F: res = {1'b1, 4'hF};
            default:   res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_capture_decode.sv
// seg_pattern_decode: combinational 7-segment pattern lookup.
//   pat    : active-low segments {a,b,c,d,e,f,g}
//   hit    : pattern is one of the 16 hex glyphs
//   nibble : decoded value (0 when hit=0)
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        {hit, nibble} = seg_decode(pat);
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reads back a multiplexed active-low 7-segment bus and
// reconstructs the displayed N_DIGITS-digit hex value.
//   clk, rst_n   : clock, synchronous active-low reset
//   seg_n        : segments {a,b,c,d,e,f,g,dp}, active-low
//   an_n         : digit selects, active-low, at most one low
//   nums         : captured nibbles, digit i at [4i+3:4i]
//   digit_valid  : digit i holds a legally decoded pattern
//   dp           : captured decimal points (only with SEG_DP_CAPTURE_EN)
//   frame_done   : pulse when every digit captured since the last pulse
//   err          : pulse on illegal select or unrecognised pattern
// Optional feature macro: SEG_DP_CAPTURE_EN (dp capture, dp in stability compare).
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned CNT_W      = 3
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_n,
    input  logic [N_DIGITS-1:0]   an_n,
    output logic [4*N_DIGITS-1:0] nums,
    output logic [N_DIGITS-1:0]   digit_valid,
`ifdef SEG_DP_CAPTURE_EN
    output logic [N_DIGITS-1:0]   dp,
`endif
    output logic                  frame_done,
    output logic                  err
);

`ifdef SEG_DP_CAPTURE_EN
    localparam int unsigned SEG_CMP_W = 8;
`else
    localparam int unsigned SEG_CMP_W = 7;
    // dp line deliberately not observed in this build
    logic unused_dp;
    assign unused_dp = seg_n[SEG_BIT_DP];
`endif
    localparam int unsigned SNAP_W = N_DIGITS + SEG_CMP_W;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    // Registered input copy; seg_q holds only the bits that take part in compare.
    logic [7:8-SEG_CMP_W]  seg_q;
    logic [N_DIGITS-1:0]   an_q;

    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SNAP_W-1:0]     snap_q, snap_d, sample;
    logic [N_DIGITS-1:0]   mask_q, mask_d, mask_next;

    logic                  an_blank, an_onehot, sel_illegal;
    logic [IDX_W-1:0]      digit_idx;
    logic                  capture, sel_err;
    logic                  hit;
    logic [3:0]            nibble;

    logic [4*N_DIGITS-1:0] nums_d;
    logic [N_DIGITS-1:0]   valid_d;
    logic                  frame_d, err_d;
`ifdef SEG_DP_CAPTURE_EN
    logic [N_DIGITS-1:0]   dp_d;
`endif

    always_comb begin
        sample      = {an_q, seg_q};
        an_blank    = &an_q;
        an_onehot   = $onehot(~an_q);
        sel_illegal = !an_blank && !an_onehot;
    end

    always_comb begin
        digit_idx = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (!an_q[i]) digit_idx = IDX_W'(i);
        end
    end

    seg_pattern_decode u_decode (
        .pat    (seg_q[7:1]),
        .hit    (hit),
        .nibble (nibble)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q       <= '1;
            an_q        <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            snap_q      <= '1;
            mask_q      <= '0;
            nums        <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
            dp          <= '0;
`endif
        end else begin
            seg_q       <= seg_n[7:8-SEG_CMP_W];
            an_q        <= an_n;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            mask_q      <= mask_d;
            nums        <= nums_d;
            digit_valid <= valid_d;
            frame_done  <= frame_d;
            err         <= err_d;
`ifdef SEG_DP_CAPTURE_EN
            dp          <= dp_d;
`endif
        end
    end

    // Next-state logic. Select legality is checked ahead of the state so an
    // illegal or blank select overrides every state uniformly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        capture = 1'b0;
        sel_err = 1'b0;
        if (sel_illegal) begin
            state_d = IDLE;
            cnt_d   = '0;
            sel_err = 1'b1;
        end else if (an_blank) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    cnt_d   = CNT_ONE;
                    snap_d  = sample;
                end
                TRACK: begin
                    if (sample == snap_q) begin
                        // Capture on the sample that brings the count to STABLE_CYC
                        if (cnt_q == CNT_LAST) begin
                            capture = 1'b1;
                            state_d = HELD;
                        end
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        snap_d = sample;
                        cnt_d  = CNT_ONE;
                    end
                end
                HELD: begin
                    if (sample != snap_q) begin
                        state_d = TRACK;
                        snap_d  = sample;
                        cnt_d   = CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: capture writes, frame completion and error pulses
    always_comb begin
        nums_d    = nums;
        valid_d   = digit_valid;
        mask_d    = mask_q;
        mask_next = mask_q;
        frame_d   = 1'b0;
        err_d     = sel_err;
`ifdef SEG_DP_CAPTURE_EN
        dp_d      = dp;
`endif
        if (capture) begin
            mask_next = mask_q | ~an_q;
            if (hit) begin
                nums_d[4*digit_idx +: 4] = nibble;
                valid_d[digit_idx]       = 1'b1;
            end else begin
                valid_d[digit_idx] = 1'b0;
                err_d              = 1'b1;
            end
`ifdef SEG_DP_CAPTURE_EN
            dp_d[digit_idx] = ~seg_q[SEG_BIT_DP];
`endif
            if (&mask_next) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d = mask_next;
            end
        end
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Reader for the board's multiplexed 7-segment display bus. Watches the active-low segment lines and the active-low digit-select lines, and decodes each stable segment pattern back into a 4-bit hex nibble.
- Reconstructs the full N_DIGITS-digit value. Used for on-board self-test and loopback of the display path.
- Sits beside the display driver and feeds its result to the debug or compare logic.

Parameters:
- N_DIGITS, 8: number of digit-select lines and captured nibbles.
- STABLE_CYC, 4: consecutive identical samples needed before a digit is accepted (≥2).
- CNT_W, 3: width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYC.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, synchronous, active-low.
- seg_n, input, 8: segment lines, active-low. Bit order {a,b,c,d,e,f,g,dp}, with bit7 = a and bit0 = dp.
- an_n, input, N_DIGITS: digit selects, active-low. At most one is low at a time.
- nums, output, 4*N_DIGITS: captured nibbles. Digit i occupies nums[4i+3:4i].
- digit_valid, output, N_DIGITS: bit i set means nums for digit i holds a legally decoded pattern.
- frame_done, output, 1: one-cycle pulse when every digit has been captured since the last pulse.
- err, output, 1: one-cycle pulse on an illegal select or an unrecognised pattern.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - nums=0, digit_valid=0, frame_done=0, err=0.
  - Capture mask cleared, stability counter=0, state=IDLE, input registers loaded with all-ones.
- Input stage:
  - seg_n and an_n are registered once.
  - Decode and compare operate on the registered copy. Capture latency = STABLE_CYC+1 cycles after the first stable sample appears on the pins.
- Decode table (seg_n[7:1], dp ignored):
  - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110
  - 4: 1001100, 5: 0100100, 6: 0100000, 7: 0001111
  - 8: 0000000, 9: 0001100, A: 0001000, b: 1100000
  - C: 1110010, d: 1000010, E: 0110000, F: 0111000
  - Any other 7-bit value is unrecognised.
- State machine:
  - IDLE: registered an_n is all-ones. Go to TRACK on a one-hot-low an_n, loading counter=1 and snapshotting {an_n, seg_n[7:1]}.
  - TRACK: each cycle, compare the current sample with the snapshot.
    - Equal: counter increments.
    - Different but still one-hot: reload the snapshot, counter=1.
    - All-ones: go to IDLE.
    - When counter reaches STABLE_CYC: perform the capture and go to HELD.
  - HELD: stay while the sample equals the snapshot.
    - Different one-hot sample: go to TRACK with counter=1.
    - All-ones: go to IDLE.
    - No repeat capture while HELD.
- Capture for digit i:
  - Recognised pattern: nums[i] gets the decoded value, digit_valid[i]=1, mask[i]=1.
  - Unrecognised pattern: nums[i] is unchanged, digit_valid[i]=0, mask[i]=1, err pulses.
- Illegal select (more than one an_n bit low), from any state:
  - err pulses, go to IDLE, counter=0. No capture.
- Frame:
  - On the cycle the mask becomes all-ones (including the capture cycle itself), frame_done pulses and the mask clears in that same cycle.
  - A digit captured twice before the frame completes overwrites its nibble; the mask bit stays set.
- Outputs are all registered. Outputs only change on a capture.
- Reset mid-TRACK aborts the pending capture. Nothing is latched.
- Counter saturates and cannot wrap. The transition to HELD bounds it at STABLE_CYC.

Optional Feature:
- Macro SEG_DP_CAPTURE_EN.
- Defined: adds output dp, N_DIGITS wide, reset to 0. On each capture of digit i, dp[i] gets ~seg_n[0]. The dp bit is included in the stability compare, so a dp change restarts TRACK.
- Undefined: no dp port, and seg_n[0] is fully ignored.

Decomposition:
- Shared package seg_pkg holds:
  - The 16 segment-pattern constants.
  - A decode function returning {hit, nibble}.
  - The state enum IDLE/TRACK/HELD.
  - The constants SEG_BLANK=8'hFF and the bit positions of a..g and dp.
- The display encoder reuses the same constants.
- Sub-module seg_pattern_decode: combinational 7→{hit,4} lookup, instantiated once.

Test Plan:
- Scan nibbles 0..7 onto digits 0..7 (an_n=~(1<<i)), holding each 6 cycles with 2 blank cycles between. Expect nums=32'h76543210, digit_valid=8'hFF, and a single frame_done pulse 5 cycles after digit 7 appears.
- Hold digit 3 with 0001000 for 3 cycles, then 0000000 for 5 cycles. Expect nums[15:12]=4'h8 only; 4'hA is never latched.
- Drive an_n=8'b1111_0011. Expect one err pulse, state IDLE, no change to nums.
- Drive seg 1111111 (not blank-select) on digit 2 for 6 cycles. Expect err pulse, digit_valid[2]=0, nums[11:8] unchanged.
- Assert rst_n=0 at cycle 3 of a TRACK on digit 5 with 4'hE. Expect all outputs 0 and no capture after release.
- With SEG_DP_CAPTURE_EN defined: digit 0 shows 0000001 with dp low (seg_n=8'h02). Expect nums[3:0]=0 and dp[0]=1.
